// File: rtl/pcs_prbs_pkg.sv
// Shared PRBS31 definitions for the PCS pattern checker.
package pcs_prbs_pkg;

  localparam int unsigned PRBS31_TAP_A = 31;
  localparam int unsigned PRBS31_TAP_B = 28;

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCK
  } lane_state_e;

endpackage

// File: rtl/pcs_prbs31_chk_lane.sv
// Single-lane self-synchronising PRBS31 checker with hunt/check/lock tracking
// and a saturating bit-error counter.
module pcs_prbs31_chk_lane
  import pcs_prbs_pkg::*;
#(
  parameter int unsigned HEAD_W    = 2,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ERR_CNT_W = 16,
  parameter int unsigned LOCK_N    = 64,
  parameter int unsigned WIN_N     = 64,
  parameter int unsigned BAD_N     = 16
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 v_i,
  input  logic [HEAD_W-1:0]    head_i,
  input  logic [DATA_W-1:0]    data_i,
  input  logic                 clear_i,
  output logic                 lock_o,
  output logic                 err_v_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int unsigned BLK_W  = HEAD_W + DATA_W;
  localparam int unsigned HIST_W = PRBS31_TAP_A;
  localparam int unsigned MM_W   = $clog2(BLK_W + 1);
  localparam int unsigned SUM_W  = ((ERR_CNT_W > MM_W) ? ERR_CNT_W : MM_W) + 1;
  localparam int unsigned GOOD_W = $clog2(LOCK_N + 1);
  localparam int unsigned WIN_W  = $clog2(WIN_N + 1);
  localparam int unsigned BAD_W  = $clog2(BAD_N + 1);

  lane_state_e           state_q;
  logic [HIST_W-1:0]     hist_q, hist_d;
  logic                  hist_v_q;
  logic [GOOD_W-1:0]     good_q, good_inc;
  logic [WIN_W-1:0]      win_q, win_inc;
  logic [BAD_W-1:0]      bad_q, bad_inc;
  logic                  lock_q;
  logic                  err_v_q;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic [BLK_W+HIST_W-1:0] ext;
  logic [BLK_W-1:0]        mism;
  logic [MM_W-1:0]         mm_cnt;
  logic [SUM_W-1:0]        sum;
  logic                    blk_err;

  // ext holds the stream oldest-first: history in the low bits, then the block
  // in serial order, so every tap is a fixed offset from the bit under test.
  always_comb begin
    ext    = {data_i, head_i, hist_q};
    mism   = '0;
    mm_cnt = '0;
    for (int unsigned j = 0; j < BLK_W; j++) begin
      mism[j] = ext[HIST_W + j] ^ ext[HIST_W + j - PRBS31_TAP_A]
                                ^ ext[HIST_W + j - PRBS31_TAP_B];
    end
    for (int unsigned j = 0; j < BLK_W; j++) begin
      mm_cnt = mm_cnt + {{(MM_W-1){1'b0}}, mism[j]};
    end
    hist_d  = ext[BLK_W+HIST_W-1:BLK_W];
    blk_err = |mism;

    sum = SUM_W'(err_cnt_q) + SUM_W'(mm_cnt);
    if (|sum[SUM_W-1:ERR_CNT_W]) begin
      err_cnt_d = '1;
    end else begin
      err_cnt_d = sum[ERR_CNT_W-1:0];
    end

    good_inc = good_q + 1'b1;
    win_inc  = win_q + 1'b1;
    bad_inc  = bad_q + BAD_W'(blk_err);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= HUNT;
      hist_q    <= '0;
      hist_v_q  <= 1'b0;
      good_q    <= '0;
      win_q     <= '0;
      bad_q     <= '0;
      lock_q    <= 1'b0;
      err_v_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_v_q <= 1'b0;
      if (clear_i) begin
        err_cnt_q <= '0;
      end
      if (v_i) begin
        hist_q   <= hist_d;
        hist_v_q <= 1'b1;
        if (hist_v_q) begin
          unique case (state_q)
            HUNT, CHECK: begin
              if (blk_err) begin
                state_q <= HUNT;
                good_q  <= '0;
                win_q   <= '0;
                bad_q   <= '0;
              end else if (good_inc == GOOD_W'(LOCK_N)) begin
                state_q <= LOCK;
                lock_q  <= 1'b1;
                good_q  <= '0;
              end else begin
                state_q <= CHECK;
                good_q  <= good_inc;
              end
            end
            LOCK: begin
              err_v_q <= blk_err;
              if (!clear_i) begin
                err_cnt_q <= err_cnt_d;
              end
              // Unlock wins over a window wrap landing on the same block.
              if (bad_inc == BAD_W'(BAD_N)) begin
                state_q <= HUNT;
                lock_q  <= 1'b0;
                good_q  <= '0;
                win_q   <= '0;
                bad_q   <= '0;
              end else if (win_inc == WIN_W'(WIN_N)) begin
                win_q <= '0;
                bad_q <= '0;
              end else begin
                win_q <= win_inc;
                bad_q <= bad_inc;
              end
            end
            default: state_q <= HUNT;
          endcase
        end
      end
    end
  end

  assign lock_o    = lock_q;
  assign err_v_o   = err_v_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: rtl/pcs_prbs31_chk.sv
// Multi-lane PRBS31 checker: one independent checker per SerDes lane.
module pcs_prbs31_chk
  import pcs_prbs_pkg::*;
#(
  parameter int unsigned LANE_N    = 4,
  parameter int unsigned HEAD_W    = 2,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ERR_CNT_W = 16,
  parameter int unsigned LOCK_N    = 64,
  parameter int unsigned WIN_N     = 64,
  parameter int unsigned BAD_N     = 16
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic [LANE_N-1:0]           serdes_v_i,
  input  logic [LANE_N*HEAD_W-1:0]    serdes_head_i,
  input  logic [LANE_N*DATA_W-1:0]    serdes_data_i,
  input  logic                        clear_i,
  output logic [LANE_N-1:0]           lock_o,
  output logic [LANE_N-1:0]           err_v_o,
  output logic [LANE_N*ERR_CNT_W-1:0] err_cnt_o
);

  for (genvar x = 0; x < LANE_N; x++) begin : g_lane
    pcs_prbs31_chk_lane #(
      .HEAD_W    (HEAD_W),
      .DATA_W    (DATA_W),
      .ERR_CNT_W (ERR_CNT_W),
      .LOCK_N    (LOCK_N),
      .WIN_N     (WIN_N),
      .BAD_N     (BAD_N)
    ) u_lane (
      .clk       (clk),
      .nreset    (nreset),
      .v_i       (serdes_v_i[x]),
      .head_i    (serdes_head_i[x*HEAD_W +: HEAD_W]),
      .data_i    (serdes_data_i[x*DATA_W +: DATA_W]),
      .clear_i   (clear_i),
      .lock_o    (lock_o[x]),
      .err_v_o   (err_v_o[x]),
      .err_cnt_o (err_cnt_o[x*ERR_CNT_W +: ERR_CNT_W])
    );
  end

endmodule

// File: tb/tb_pcs_prbs31_chk.sv
// Directed-vector bench for pcs_prbs31_chk: a 16-bit and a 4-bit counter
// instance share the same per-lane PRBS31 stimulus.
module tb_pcs_prbs31_chk;

  localparam int L  = 4;
  localparam int HW = 2;
  localparam int DW = 64;
  localparam int BW = HW + DW;

  logic            clk = 1'b0;
  logic            nreset;
  logic [L-1:0]    v;
  logic [L*HW-1:0] head;
  logic [L*DW-1:0] data;
  logic            clear;
  logic [L-1:0]    lock, errv, lock4, errv4;
  logic [L*16-1:0] cnt;
  logic [L*4-1:0]  cnt4;

  always #5 clk = ~clk;

  pcs_prbs31_chk #(
    .LANE_N(4), .HEAD_W(2), .DATA_W(64), .ERR_CNT_W(16),
    .LOCK_N(64), .WIN_N(64), .BAD_N(16)
  ) dut (
    .clk(clk), .nreset(nreset), .serdes_v_i(v), .serdes_head_i(head),
    .serdes_data_i(data), .clear_i(clear), .lock_o(lock), .err_v_o(errv),
    .err_cnt_o(cnt)
  );

  pcs_prbs31_chk #(
    .LANE_N(4), .HEAD_W(2), .DATA_W(64), .ERR_CNT_W(4),
    .LOCK_N(64), .WIN_N(64), .BAD_N(16)
  ) dut4 (
    .clk(clk), .nreset(nreset), .serdes_v_i(v), .serdes_head_i(head),
    .serdes_data_i(data), .clear_i(clear), .lock_o(lock4), .err_v_o(errv4),
    .err_cnt_o(cnt4)
  );

  typedef struct {
    int          n;
    logic [3:0]  vmask;
    int          flane;
    int          fpos;
    bit          clr;
    bit          rst;
    logic [3:0]  lock;
    logic [3:0]  errv;
    logic [63:0] cnt;
  } vec_t;

  vec_t        tbl[$];
  logic [30:0] g[L];
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic push(input int n, input logic [3:0] vm, input int fl, input int fp,
                      input bit clr, input bit rst, input logic [3:0] lk,
                      input logic [3:0] ev, input int c0, input int c1,
                      input int c2, input int c3);
    vec_t e;
    e.n = n; e.vmask = vm; e.flane = fl; e.fpos = fp; e.clr = clr; e.rst = rst;
    e.lock = lk; e.errv = ev;
    e.cnt = {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    tbl.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One block per lane; lanes not valid get random garbage that must be ignored.
  task automatic drive_block(input logic [3:0] vm, input int fl, input int fp, input bit clr);
    logic [BW-1:0] blk;
    logic          nb;
    for (int l = 0; l < L; l++) begin
      if (vm[l]) begin
        for (int j = 0; j < BW; j++) begin
          nb     = g[l][0] ^ g[l][3];
          g[l]   = {nb, g[l][30:1]};
          blk[j] = nb;
        end
        if (fl == l) blk[fp] = ~blk[fp];
        head[l*HW +: HW] = blk[HW-1:0];
        data[l*DW +: DW] = blk[BW-1:HW];
      end else begin
        head[l*HW +: HW] = 2'($urandom);
        data[l*DW +: DW] = {$urandom, $urandom};
      end
    end
    v     = vm;
    clear = clr;
    @(posedge clk);
    #1;
    v     = '0;
    clear = 1'b0;
  endtask

  function automatic logic [15:0] sat4(input logic [63:0] c);
    logic [15:0] r;
    for (int l = 0; l < L; l++) begin
      r[l*4 +: 4] = (c[l*16 +: 16] > 16'd15) ? 4'hF : c[l*16 + 3 -: 4];
    end
    return r;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    nreset = 1'b0;
    v      = '0;
    clear  = 1'b0;
    head   = '0;
    data   = '0;
    g[0] = 31'h0000_0001;
    g[1] = 31'h5A5A_5A5A;
    g[2] = 31'h1234_5678;
    g[3] = 31'h7FFF_0001;

    // Full fill: first block loads history, 64 more clean blocks lock.
    push(64, 4'hF, -1, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0);
    push(1,  4'hF, -1, 0, 0, 0, 4'hF, 4'h0, 0, 0, 0, 0);
    // Lane 2 data bit 10 (serial position 12): flip plus two tap echoes.
    push(1,  4'hF, 2, 12, 0, 0, 4'hF, 4'h4, 0, 0, 3, 0);
    push(1,  4'hF, -1, 0, 0, 0, 4'hF, 4'h0, 0, 0, 3, 0);
    // Clear coincident with an errored locked block discards its errors.
    push(1,  4'hF, 2, 12, 1, 0, 4'hF, 4'h4, 0, 0, 0, 0);
    // Six isolated flips on lane 0: 18 errors, the 4-bit counter sticks at 15.
    for (int i = 0; i < 6; i++) begin
      push(1, 4'hF, 0, 2, 0, 0, 4'hF, 4'h1, 3*(i+1), 0, 0, 0);
      push(1, 4'hF, -1, 0, 0, 0, 4'hF, 4'h0, 3*(i+1), 0, 0, 0);
    end
    // Cross a window boundary so lane 0's bad count starts fresh.
    push(52, 4'hF, -1, 0, 0, 0, 4'hF, 4'h0, 18, 0, 0, 0);
    // Sixteen errored blocks in 31: unlock on the 16th, which still counts.
    for (int i = 0; i < 15; i++) begin
      push(1, 4'hF, 0, 2, 0, 0, 4'hF, 4'h1, 18+3*(i+1), 0, 0, 0);
      push(1, 4'hF, -1, 0, 0, 0, 4'hF, 4'h0, 18+3*(i+1), 0, 0, 0);
    end
    push(1,  4'hF, 0, 2, 0, 0, 4'hE, 4'h1, 66, 0, 0, 0);
    push(1,  4'hF, -1, 0, 0, 0, 4'hE, 4'h0, 66, 0, 0, 0);
    // Errored block while checking: back to hunt, not counted, no pulse.
    push(1,  4'hF, 0, 2, 0, 0, 4'hE, 4'h0, 66, 0, 0, 0);
    push(63, 4'hF, -1, 0, 0, 0, 4'hE, 4'h0, 66, 0, 0, 0);
    push(1,  4'hF, -1, 0, 0, 0, 4'hF, 4'h0, 66, 0, 0, 0);
    // Valid gaps and partial lane masks.
    push(5,  4'h0, -1, 0, 0, 0, 4'hF, 4'h0, 66, 0, 0, 0);
    push(1,  4'hF, 3, 12, 0, 0, 4'hF, 4'h8, 66, 0, 0, 3);
    push(1,  4'hA, 1, 12, 0, 0, 4'hF, 4'h2, 66, 3, 0, 3);
    push(2,  4'h0, -1, 0, 0, 0, 4'hF, 4'h0, 66, 3, 0, 3);
    push(1,  4'hA, 1, 12, 0, 0, 4'hF, 4'h2, 66, 6, 0, 3);
    push(1,  4'h0, -1, 0, 0, 0, 4'hF, 4'h0, 66, 6, 0, 3);
    push(3,  4'h5, -1, 0, 0, 0, 4'hF, 4'h0, 66, 6, 0, 3);
    push(1,  4'hF, -1, 0, 0, 0, 4'hF, 4'h0, 66, 6, 0, 3);
    // Reset mid-stream, then full relock.
    push(64, 4'hF, -1, 0, 0, 1, 4'h0, 4'h0, 0, 0, 0, 0);
    push(1,  4'hF, -1, 0, 0, 0, 4'hF, 4'h0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset lock",  64'(lock),  64'h0);
    chk("reset errv",  64'(errv),  64'h0);
    chk("reset cnt",   cnt,        64'h0);
    chk("reset cnt4",  64'(cnt4),  64'h0);
    nreset = 1'b1;

    for (int r = 0; r < tbl.size(); r++) begin
      if (tbl[r].rst) begin
        nreset = 1'b0;
        #2;
        chk($sformatf("row%0d async rst lock", r), 64'({lock4, lock}), 64'h0);
        chk($sformatf("row%0d async rst errv", r), 64'({errv4, errv}), 64'h0);
        chk($sformatf("row%0d async rst cnt", r),  cnt,                64'h0);
        chk($sformatf("row%0d async rst cnt4", r), 64'(cnt4),          64'h0);
        #2;
        nreset = 1'b1;
      end
      for (int k = 0; k < tbl[r].n; k++) begin
        drive_block(tbl[r].vmask, tbl[r].flane, tbl[r].fpos, tbl[r].clr);
      end
      chk($sformatf("row%0d lock", r),  64'(lock),  64'(tbl[r].lock));
      chk($sformatf("row%0d errv", r),  64'(errv),  64'(tbl[r].errv));
      chk($sformatf("row%0d cnt", r),   cnt,        tbl[r].cnt);
      chk($sformatf("row%0d lock4", r), 64'(lock4), 64'(tbl[r].lock));
      chk($sformatf("row%0d errv4", r), 64'(errv4), 64'(tbl[r].errv));
      chk($sformatf("row%0d cnt4", r),  64'(cnt4),  64'(sat4(tbl[r].cnt)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
